// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//   Program-loader back end. Accepts decoded LEGv8 operations, assembles the
//   32-bit instruction word, and queues it in a DEPTH-entry FIFO. The FIFO
//   writes each word into instruction memory at consecutive byte addresses
//   (+4 per word, wrapping modulo 2**AW).
//
//   Handshakes (both sides): a transfer happens on a rising clock edge
//   where valid and ready are both 1. Valid never depends on ready.
//   While valid=1 and ready=0, the payload holds stable.
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   in_valid   in   1   operation offered
//   in_ready   out  1   operation can be accepted (FIFO not full)
//   in_kind    in   3   0 LDUR,1 STUR,2 CBZ,3 ADD,4 SUB,5 AND,6 ORR,7 illegal
//   in_rd      in   5   Rd (R-type) / Rt (LDUR, STUR, CBZ)
//   in_rn      in   5   Rn (R-type, LDUR, STUR)
//   in_rm      in   5   Rm (R-type)
//   in_imm     in   19  D-type DT_address in [8:0]; CBZ offset in [18:0]
//   load_base  in   1   pulse: reload the write-address counter
//   base_addr  in   AW  new write byte address
//   iw_valid   out  1   head word available
//   iw_ready   in   1   imem accepts the write this cycle
//   iw_addr    out  AW  imem byte address of the head word
//   iw_data    out  32  head instruction word
//   wr_count   out  16  words written since reset (saturating)
//   err        out  1   sticky: an illegal kind was accepted
// ----------------------------------------------------------------------------
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_kind,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rn,
  input  logic [4:0]    in_rm,
  input  logic [18:0]   in_imm,
  input  logic          load_base,
  input  logic [AW-1:0] base_addr,
  output logic          iw_valid,
  input  logic          iw_ready,
  output logic [AW-1:0] iw_addr,
  output logic [31:0]   iw_data,
  output logic [15:0]   wr_count,
  output logic          err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] LP_FULL = (PW+1)'(DEPTH);

  localparam logic [2:0] K_LDUR = 3'd0;
  localparam logic [2:0] K_STUR = 3'd1;
  localparam logic [2:0] K_CBZ  = 3'd2;
  localparam logic [2:0] K_ADD  = 3'd3;
  localparam logic [2:0] K_SUB  = 3'd4;
  localparam logic [2:0] K_AND  = 3'd5;
  localparam logic [2:0] K_ORR  = 3'd6;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;

  logic [31:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_wr_count;
  logic          r_err;

  logic [31:0]   w_enc_word;
  logic          w_illegal;
  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;

  // Encoder: pure function of the operation fields.
  always_comb begin
    w_enc_word = 32'h0;
    w_illegal  = 1'b0;
    case (in_kind)
      K_LDUR:  w_enc_word = {OP_LDUR, in_imm[8:0], 2'b00, in_rn, in_rd};
      K_STUR:  w_enc_word = {OP_STUR, in_imm[8:0], 2'b00, in_rn, in_rd};
      K_CBZ:   w_enc_word = {OP_CBZ, in_imm, in_rd};
      K_ADD:   w_enc_word = {OP_ADD, in_rm, 6'b0, in_rn, in_rd};
      K_SUB:   w_enc_word = {OP_SUB, in_rm, 6'b0, in_rn, in_rd};
      K_AND:   w_enc_word = {OP_AND, in_rm, 6'b0, in_rn, in_rd};
      K_ORR:   w_enc_word = {OP_ORR, in_rm, 6'b0, in_rn, in_rd};
      default: w_illegal  = 1'b1;
    endcase
  end

  assign w_full   = (r_count == LP_FULL);
  assign w_empty  = (r_count == '0);
  // Ready depends on fullness only, so a pop never frees a slot in the same cycle.
  assign in_ready = !w_full;
  assign w_accept = in_valid && in_ready;
  // Illegal kinds are consumed without entering the FIFO.
  assign w_push   = w_accept && !w_illegal;
  assign w_pop    = !w_empty && iw_ready;

  // FIFO storage carries no reset; occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_enc_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Write-address counter tracks the head word; load_base overrides a pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
    end else if (load_base) begin
      r_addr <= base_addr;
    end else if (w_pop) begin
      r_addr <= r_addr + AW'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_count <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_pop && (r_wr_count != 16'hFFFF)) r_wr_count <= r_wr_count + 16'd1;
      if (w_accept && w_illegal)             r_err      <= 1'b1;
    end
  end

  assign iw_valid = !w_empty;
  assign iw_data  = r_mem[r_rptr];
  assign iw_addr  = r_addr;
  assign wr_count = r_wr_count;
  assign err      = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder
//   Directed bench for instr_encoder: encodings, FIFO stall/ordering,
//   illegal kind handling, base-address load/wrap, and reset mid-operation.
// ----------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_kind;
  logic [4:0]    in_rd;
  logic [4:0]    in_rn;
  logic [4:0]    in_rm;
  logic [18:0]   in_imm;
  logic          load_base;
  logic [AW-1:0] base_addr;
  logic          iw_valid;
  logic          iw_ready;
  logic [AW-1:0] iw_addr;
  logic [31:0]   iw_data;
  logic [15:0]   wr_count;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]   exp_q[$];
  logic [AW-1:0] exp_a[$];

  instr_encoder #(.DEPTH(4), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_rd     (in_rd),
    .in_rn     (in_rn),
    .in_rm     (in_rm),
    .in_imm    (in_imm),
    .load_base (load_base),
    .base_addr (base_addr),
    .iw_valid  (iw_valid),
    .iw_ready  (iw_ready),
    .iw_addr   (iw_addr),
    .iw_data   (iw_data),
    .wr_count  (wr_count),
    .err       (err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    load_base = 1'b0;
    iw_ready  = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_op(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rn,
                          input logic [4:0] rm, input logic [18:0] imm);
    in_valid = 1'b1;
    in_kind  = k;
    in_rd    = rd;
    in_rn    = rn;
    in_rm    = rm;
    in_imm   = imm;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    in_kind = 3'd0; in_rd = '0; in_rn = '0; in_rm = '0; in_imm = '0; base_addr = '0;
    do_reset();
    n_checks++; if (iw_valid !== 1'b0) begin n_fail++; $display("FAIL rst_iw_valid got=%0b exp=0", iw_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    n_checks++; if (iw_addr !== 8'h00) begin n_fail++; $display("FAIL rst_iw_addr got=%0h exp=0", iw_addr); end
    n_checks++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL rst_wr_count got=%0d exp=0", wr_count); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%0b exp=0", err); end
  endtask

  task automatic test_encodings();
    logic [31:0] words [3];
    words[0] = 32'h8B020023; // ADD X3,X1,X2
    words[1] = 32'hF84402C9; // LDUR X9,[X22,#64]
    words[2] = 32'hB4FFFFA5; // CBZ X5,-3
    do_reset();
    iw_ready = 1'b1;
    drive_op(3'd3, 5'd3, 5'd1, 5'd2, 19'd0);
    step();
    in_valid = 1'b0;
    n_checks++; if (iw_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got=%0b exp=1", iw_valid); end
    n_checks++; if (iw_data !== words[0]) begin n_fail++; $display("FAIL add_data got=%h exp=%h", iw_data, words[0]); end
    n_checks++; if (iw_addr !== 8'h00) begin n_fail++; $display("FAIL add_addr got=%h exp=00", iw_addr); end
    step();
    n_checks++; if (wr_count !== 16'd1) begin n_fail++; $display("FAIL add_wr_count got=%0d exp=1", wr_count); end
    n_checks++; if (iw_valid !== 1'b0) begin n_fail++; $display("FAIL add_drained got=%0b exp=0", iw_valid); end
    drive_op(3'd0, 5'd9, 5'd22, 5'd31, 19'd64);
    step();
    in_valid = 1'b0;
    n_checks++; if (iw_data !== words[1]) begin n_fail++; $display("FAIL ldur_data got=%h exp=%h", iw_data, words[1]); end
    n_checks++; if (iw_addr !== 8'h04) begin n_fail++; $display("FAIL ldur_addr got=%h exp=04", iw_addr); end
    step();
    drive_op(3'd2, 5'd5, 5'd7, 5'd8, 19'h7FFFD);
    step();
    in_valid = 1'b0;
    n_checks++; if (iw_data !== words[2]) begin n_fail++; $display("FAIL cbz_data got=%h exp=%h", iw_data, words[2]); end
    n_checks++; if (iw_addr !== 8'h08) begin n_fail++; $display("FAIL cbz_addr got=%h exp=08", iw_addr); end
    step();
    n_checks++; if (wr_count !== 16'd3) begin n_fail++; $display("FAIL enc_wr_count got=%0d exp=3", wr_count); end
  endtask

  task automatic test_stall();
    logic [31:0] hold;
    do_reset();
    exp_q.delete();
    exp_q.push_back(32'hCB0600A4); drive_op(3'd4, 5'd4, 5'd5, 5'd6, 19'd0);  step(); // SUB X4,X5,X6
    exp_q.push_back(32'h8A090107); drive_op(3'd5, 5'd7, 5'd8, 5'd9, 19'd0);  step(); // AND X7,X8,X9
    exp_q.push_back(32'hAA0C016A); drive_op(3'd6, 5'd10, 5'd11, 5'd12, 19'd0); // ORR X10,X11,X12
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready3 got=%0b exp=1", in_ready); end
    step();
    exp_q.push_back(32'hF8008041); drive_op(3'd1, 5'd1, 5'd2, 5'd0, 19'd8);  step(); // STUR X1,[X2,#8]
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_full got=%0b exp=0", in_ready); end
    // Offered while full: must not be taken.
    drive_op(3'd3, 5'd3, 5'd1, 5'd2, 19'd0);
    hold = iw_data;
    step(); step();
    in_valid = 1'b0;
    n_checks++; if (iw_data !== hold || iw_data !== exp_q[0]) begin n_fail++; $display("FAIL stall_hold got=%h exp=%h", iw_data, exp_q[0]); end
    n_checks++; if (iw_addr !== 8'h00) begin n_fail++; $display("FAIL stall_hold_addr got=%h exp=00", iw_addr); end
    iw_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (iw_valid !== 1'b1 || iw_data !== exp_q[i] || iw_addr !== AW'(4*i)) begin
        n_fail++;
        $display("FAIL drain_%0d got v=%0b d=%h a=%h exp v=1 d=%h a=%h", i, iw_valid, iw_data, iw_addr, exp_q[i], AW'(4*i));
      end
      step();
    end
    n_checks++; if (iw_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%0b exp=0", iw_valid); end
    n_checks++; if (wr_count !== 16'd4) begin n_fail++; $display("FAIL drain_count got=%0d exp=4", wr_count); end
  endtask

  task automatic test_illegal();
    do_reset();
    iw_ready = 1'b1;
    drive_op(3'd7, 5'd1, 5'd1, 5'd1, 19'd1);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ready got=%0b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err got=%0b exp=1", err); end
    n_checks++; if (iw_valid !== 1'b0) begin n_fail++; $display("FAIL ill_no_valid got=%0b exp=0", iw_valid); end
    step();
    n_checks++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL ill_count got=%0d exp=0", wr_count); end
    drive_op(3'd4, 5'd4, 5'd5, 5'd6, 19'd0);
    step();
    in_valid = 1'b0;
    n_checks++; if (iw_data !== 32'hCB0600A4 || iw_addr !== 8'h00) begin n_fail++; $display("FAIL ill_sub got d=%h a=%h exp d=cb0600a4 a=00", iw_data, iw_addr); end
    step();
    n_checks++; if (err !== 1'b1 || wr_count !== 16'd1) begin n_fail++; $display("FAIL ill_sticky got err=%0b cnt=%0d exp err=1 cnt=1", err, wr_count); end
  endtask

  task automatic test_load_base();
    do_reset();
    load_base = 1'b1; base_addr = 8'hFC;
    step();
    load_base = 1'b0;
    n_checks++; if (iw_addr !== 8'hFC) begin n_fail++; $display("FAIL lb_load got=%h exp=fc", iw_addr); end
    drive_op(3'd1, 5'd1, 5'd2, 5'd0, 19'd8); step();
    drive_op(3'd5, 5'd7, 5'd8, 5'd9, 19'd0); step();
    in_valid = 1'b0;
    iw_ready = 1'b1;
    n_checks++; if (iw_data !== 32'hF8008041 || iw_addr !== 8'hFC) begin n_fail++; $display("FAIL lb_first got d=%h a=%h exp d=f8008041 a=fc", iw_data, iw_addr); end
    step();
    n_checks++; if (iw_data !== 32'h8A090107 || iw_addr !== 8'h00) begin n_fail++; $display("FAIL lb_wrap got d=%h a=%h exp d=8a090107 a=00", iw_data, iw_addr); end
    step();
    iw_ready = 1'b0;
    drive_op(3'd6, 5'd10, 5'd11, 5'd12, 19'd0); step();
    drive_op(3'd3, 5'd3, 5'd1, 5'd2, 19'd0);    step();
    in_valid = 1'b0;
    n_checks++; if (iw_data !== 32'hAA0C016A || iw_addr !== 8'h04) begin n_fail++; $display("FAIL lb_pre got d=%h a=%h exp d=aa0c016a a=04", iw_data, iw_addr); end
    // Pop and load in the same cycle: base wins.
    iw_ready = 1'b1; load_base = 1'b1; base_addr = 8'h40;
    step();
    load_base = 1'b0;
    n_checks++; if (iw_data !== 32'h8B020023 || iw_addr !== 8'h40) begin n_fail++; $display("FAIL lb_coincide got d=%h a=%h exp d=8b020023 a=40", iw_data, iw_addr); end
    step();
    n_checks++; if (iw_addr !== 8'h44 || wr_count !== 16'd4) begin n_fail++; $display("FAIL lb_after got a=%h cnt=%0d exp a=44 cnt=4", iw_addr, wr_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_q.delete();
    exp_a.delete();
    iw_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin drive_op(3'd3, 5'd3, 5'd1, 5'd2, 19'd0);      exp_q.push_back(32'h8B020023); end
        1: begin drive_op(3'd0, 5'd9, 5'd22, 5'd0, 19'd64);    exp_q.push_back(32'hF84402C9); end
        2: begin drive_op(3'd2, 5'd5, 5'd0, 5'd0, 19'h7FFFD);  exp_q.push_back(32'hB4FFFFA5); end
        3: begin drive_op(3'd4, 5'd4, 5'd5, 5'd6, 19'd0);      exp_q.push_back(32'hCB0600A4); end
        default: begin drive_op(3'd6, 5'd10, 5'd11, 5'd12, 19'd0); exp_q.push_back(32'hAA0C016A); end
      endcase
      exp_a.push_back(AW'(4*i));
      step();
      n_checks++;
      if (iw_valid !== 1'b1 || iw_data !== exp_q[i] || iw_addr !== exp_a[i]) begin
        n_fail++;
        $display("FAIL b2b_%0d got v=%0b d=%h a=%h exp v=1 d=%h a=%h", i, iw_valid, iw_data, iw_addr, exp_q[i], exp_a[i]);
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++; if (iw_valid !== 1'b0 || wr_count !== 16'd5) begin n_fail++; $display("FAIL b2b_end got v=%0b cnt=%0d exp v=0 cnt=5", iw_valid, wr_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_base = 1'b1; base_addr = 8'h20;
    step();
    load_base = 1'b0;
    drive_op(3'd3, 5'd3, 5'd1, 5'd2, 19'd0); step();
    drive_op(3'd4, 5'd4, 5'd5, 5'd6, 19'd0); step();
    drive_op(3'd7, 5'd0, 5'd0, 5'd0, 19'd0); step();
    drive_op(3'd5, 5'd7, 5'd8, 5'd9, 19'd0); step();
    in_valid = 1'b0;
    n_checks++; if (iw_valid !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL mid_pre got v=%0b err=%0b exp v=1 err=1", iw_valid, err); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (iw_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst got v=%0b rdy=%0b exp v=0 rdy=1", iw_valid, in_ready); end
    n_checks++; if (wr_count !== 16'd0 || iw_addr !== 8'h00 || err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state got cnt=%0d a=%h err=%0b exp 0/00/0", wr_count, iw_addr, err); end
    iw_ready = 1'b1;
    step(); step();
    n_checks++; if (iw_valid !== 1'b0 || wr_count !== 16'd0) begin n_fail++; $display("FAIL mid_no_write got v=%0b cnt=%0d exp v=0 cnt=0", iw_valid, wr_count); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_encodings();
    test_stall();
    test_illegal();
    test_load_base();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
